// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg
// Shared widths, bus typedefs, the per-entry record and tag helpers for the
// 16-entry reorder buffer. Tags run 1..ROB_DEPTH; tag 0 means "no dependency".
// No ports (package).
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 5;
  localparam int VAL_W     = 32;
  localparam int ADDR_W    = 32;
  localparam int REG_W     = 5;
  localparam int IDX_W     = $clog2(ROB_DEPTH);

  typedef logic [TAG_W-1:0]  ROBTagBus;
  typedef logic [REG_W-1:0]  RegBus;
  typedef logic [VAL_W-1:0]  RegValBus;
  typedef logic [ADDR_W-1:0] AddrBus;

  localparam ROBTagBus TAG_NONE  = ROBTagBus'(0);
  localparam ROBTagBus TAG_FIRST = ROBTagBus'(1);
  localparam ROBTagBus TAG_LAST  = ROBTagBus'(ROB_DEPTH);

  typedef struct packed {
    logic     busy;
    logic     ready;
    logic     has_rd;
    RegBus    rd;
    RegValBus val;
    AddrBus   pc;
    logic     is_branch;
    logic     pred_taken;
    logic     taken;
    AddrBus   target;
    logic     is_store;
  } rob_entry_t;

  // Tags are 1-based while storage is 0-based, so tag N lives in slot N-1.
  function automatic logic [IDX_W-1:0] tag_to_idx(input ROBTagBus tag);
    ROBTagBus zeroBased;
    zeroBased = tag - TAG_FIRST;
    return zeroBased[IDX_W-1:0];
  endfunction

  // Only tags 1..ROB_DEPTH name a real entry.
  function automatic logic tag_in_range(input ROBTagBus tag);
    return (tag != TAG_NONE) && (tag <= TAG_LAST);
  endfunction

endpackage

// File: rtl/reorder_buffer_ptr_inc.sv
// reorder_buffer_ptr_inc
// Advances a ROB tag pointer by one with wrap-around (ROB_DEPTH -> 1).
// Shared by the head and tail pointers.
// Ports:
//   ptr_i  current tag (1..ROB_DEPTH)
//   ptr_o  following tag
module reorder_buffer_ptr_inc
  import reorder_buffer_pkg::*;
(
  input  logic [TAG_W-1:0] ptr_i,
  output logic [TAG_W-1:0] ptr_o
);

  // Tag 0 is reserved for "no dependency", so the wrap goes back to 1.
  assign ptr_o = (ptr_i == TAG_LAST) ? TAG_FIRST : (ptr_i + TAG_FIRST);

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer
// 16-entry circular reorder buffer. Hands out tags at dispatch, captures CDB
// results, retires in order one per cycle into the register file, and flushes
// the machine on a branch mispredict detected at commit.
// Ports:
//   clk_in, rst_in, rdy_in        clock, sync active-high reset, global enable
//   alloc_*                       dispatch request and instruction fields
//   next_tag, rob_full            tail tag for the next allocation, full flag
//   cdb_*                         result broadcast (tag, value, branch outcome)
//   write_rdy, rd, write_val      registered commit to the register file
//   now_tag                       head tag (already past this cycle's commit)
//   clear, clear_pc               flush pulse and fetch redirect target
//   store_commit                  head store retired, LSB performs the write
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              alloc_valid,
  input  logic              alloc_has_rd,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              alloc_is_branch,
  input  logic              alloc_pred_taken,
  input  logic              alloc_is_store,
  output logic [TAG_W-1:0]  next_tag,
  output logic              rob_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [VAL_W-1:0]  cdb_val,
  input  logic              cdb_taken,
  input  logic [ADDR_W-1:0] cdb_target,
  output logic              write_rdy,
  output logic [REG_W-1:0]  rd,
  output logic [VAL_W-1:0]  write_val,
  output logic [TAG_W-1:0]  now_tag,
  output logic              clear,
  output logic [ADDR_W-1:0] clear_pc,
  output logic              store_commit
);

  rob_entry_t  entries_q [ROB_DEPTH];
  ROBTagBus    head_q, tail_q;
  ROBTagBus    head_inc, tail_inc;
  logic [TAG_W-1:0] count_q, count_d;

  logic        write_rdy_q, store_commit_q, clear_q;
  RegBus       rd_q;
  RegValBus    write_val_q;
  AddrBus      clear_pc_q;

  logic [IDX_W-1:0] head_idx, tail_idx, cdb_idx;
  rob_entry_t  head_e;
  logic        alloc_en, cdb_en, commit_en, mispredict;
  AddrBus      redirect_pc;

  reorder_buffer_ptr_inc u_head_inc (.ptr_i(head_q), .ptr_o(head_inc));
  reorder_buffer_ptr_inc u_tail_inc (.ptr_i(tail_q), .ptr_o(tail_inc));

  // Decode this cycle's allocate / writeback / commit decisions. Commit only
  // looks at the registered ready bit, so a CDB hit on the head entry retires
  // one cycle later. While the flush pulse is out, dispatch and CDB traffic
  // belong to the squashed path and are dropped.
  always_comb begin
    head_idx    = tag_to_idx(head_q);
    tail_idx    = tag_to_idx(tail_q);
    cdb_idx     = tag_to_idx(cdb_tag);
    head_e      = entries_q[head_idx];
    alloc_en    = alloc_valid && !rob_full && !clear_q;
    cdb_en      = cdb_valid && !clear_q && tag_in_range(cdb_tag)
                  && entries_q[cdb_idx].busy;
    commit_en   = head_e.busy && head_e.ready;
    mispredict  = commit_en && head_e.is_branch
                  && (head_e.taken != head_e.pred_taken);
    redirect_pc = head_e.taken ? head_e.target : (head_e.pc + AddrBus'(4));
  end

  // Occupancy: an allocate and a commit in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (alloc_en && !commit_en) begin
      count_d = count_q + 5'd1;
    end else if (!alloc_en && commit_en) begin
      count_d = count_q - 5'd1;
    end
  end

  // Main state update. Everything is frozen while rdy_in is low. A mispredict
  // overrides the normal pointer/count updates and empties the buffer, since
  // every entry younger than the branch is on the wrong path.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q         <= TAG_FIRST;
      tail_q         <= TAG_FIRST;
      count_q        <= '0;
      write_rdy_q    <= 1'b0;
      store_commit_q <= 1'b0;
      clear_q        <= 1'b0;
      rd_q           <= '0;
      write_val_q    <= '0;
      clear_pc_q     <= '0;
    end else if (rdy_in) begin
      write_rdy_q    <= commit_en && head_e.has_rd;
      store_commit_q <= commit_en && head_e.is_store;
      clear_q        <= mispredict;

      if (commit_en) begin
        rd_q                     <= head_e.rd;
        write_val_q              <= head_e.val;
        entries_q[head_idx].busy <= 1'b0;
      end

      if (mispredict) begin
        clear_pc_q <= redirect_pc;
      end

      if (cdb_en) begin
        entries_q[cdb_idx].ready  <= 1'b1;
        entries_q[cdb_idx].val    <= cdb_val;
        entries_q[cdb_idx].taken  <= cdb_taken;
        entries_q[cdb_idx].target <= cdb_target;
      end

      // Stores have nothing to wait for on the CDB, so they start out ready.
      if (alloc_en) begin
        entries_q[tail_idx] <= '{busy:       1'b1,
                                 ready:      alloc_is_store,
                                 has_rd:     alloc_has_rd,
                                 rd:         alloc_rd,
                                 val:        '0,
                                 pc:         alloc_pc,
                                 is_branch:  alloc_is_branch,
                                 pred_taken: alloc_pred_taken,
                                 taken:      1'b0,
                                 target:     '0,
                                 is_store:   alloc_is_store};
      end

      if (mispredict) begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
          entries_q[i].busy <= 1'b0;
        end
        head_q  <= TAG_FIRST;
        tail_q  <= TAG_FIRST;
        count_q <= '0;
      end else begin
        if (commit_en) head_q <= head_inc;
        if (alloc_en)  tail_q <= tail_inc;
        count_q <= count_d;
      end
    end
  end

  assign next_tag     = tail_q;
  assign now_tag      = head_q;
  assign rob_full     = (count_q == TAG_W'(ROB_DEPTH));
  assign write_rdy    = write_rdy_q;
  assign rd           = rd_q;
  assign write_val    = write_val_q;
  assign store_commit = store_commit_q;
  assign clear        = clear_q;
  assign clear_pc     = clear_pc_q;

endmodule
